// File: rtl/dff_pipe_elastic_if.sv
// Valid/ready/data stream bundle used on both the producer and consumer side
// of the elastic pipeline.
interface dff_pipe_elastic_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/dff_pipe_elastic.sv
// Elastic DEPTH-stage register pipeline: per-stage valid bits, valid/ready
// handshake with bubble collapse, synchronous flush and occupancy count.
module dff_pipe_elastic #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  localparam int unsigned     CW      = (DEPTH + 1 > 2) ? $clog2(DEPTH + 1) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  dff_pipe_elastic_if.slave  in_if,
  dff_pipe_elastic_if.master out_if,
  output logic [CW-1:0]      count
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DEPTH-1:0] r_s;
  logic             src_v_s;

  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] bits);
    logic [CW-1:0] acc;
    acc = {CW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      acc = acc + CW'(bits[i]);
    end
    return acc;
  endfunction

  assign src_v_s = in_if.valid & ~flush;

  // Ready ripples back from the consumer; any empty stage re-opens everything upstream of it.
  always_comb begin
    logic chain;
    chain = out_if.ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain  = chain | ~v_q[i];
      r_s[i] = chain;
    end
  end

  // Stage advance: a ready stage takes its upstream valid; data moves only with a valid word.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = {DEPTH{1'b0}};
    end else begin
      if (r_s[0]) begin
        v_d[0] = src_v_s;
        if (src_v_s) begin
          d_d[0] = in_if.data;
        end else begin
          d_d[0] = d_q[0];
        end
      end else begin
        v_d[0] = v_q[0];
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (r_s[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1]) begin
            d_d[i] = d_q[i-1];
          end else begin
            d_d[i] = d_q[i];
          end
        end else begin
          v_d[i] = v_q[i];
        end
      end
    end
  end

  // Stage registers; reset beats flush and every handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= RST_VAL;
      end
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  // out_ready -> in_ready is a deliberate combinational path (no skid buffer).
  assign in_if.ready  = r_s[0] & ~flush;
  assign out_if.valid = v_q[DEPTH-1];
  assign out_if.data  = d_q[DEPTH-1];
  assign count        = popcount(v_q);

endmodule
